// File: rtl/psum_acc_pkg.sv
// Shared definitions for the partial-sum accumulator: default widths,
// FSM state encoding and saturation-limit helpers.
package psum_acc_pkg;

    localparam int unsigned DEF_F_WIDTH   = 8;
    localparam int unsigned DEF_I_WIDTH   = 8;
    localparam int unsigned DEF_ACC_WIDTH = 24;
    localparam int unsigned DEF_PASS_W    = 4;
    localparam int unsigned DEF_DEPTH     = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Limits returned in 64 bits; callers truncate to their accumulator width.
    function automatic logic [63:0] sat_max(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] sat_min(input int unsigned w);
        return ~sat_max(w);
    endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous result FIFO with full/empty/count status; head output holds
// the last popped value while empty.
module psum_fifo
    import psum_acc_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [WIDTH-1:0] last_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign data_o  = empty_o ? last_q : mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            last_q   <= '0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop_ok) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/psum_acc.sv
// Multi-pass saturating partial-sum accumulator feeding a result FIFO.
// Define PSUM_ACC_RELU_EN to clamp negative results to zero at the FIFO input.
module psum_acc
    import psum_acc_pkg::*;
#(
    parameter int unsigned F_WIDTH   = DEF_F_WIDTH,
    parameter int unsigned I_WIDTH   = DEF_I_WIDTH,
    parameter int unsigned ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int unsigned PASS_W    = DEF_PASS_W,
    parameter int unsigned DEPTH     = DEF_DEPTH
) (
    input  logic                              clk_i,
    input  logic                              acc_rst_i,
    input  logic signed [F_WIDTH+I_WIDTH-1:0] psum_i,
    input  logic                              psum_valid_i,
    output logic                              psum_ready_o,
    input  logic [PASS_W-1:0]                 num_passes_i,
    output logic signed [ACC_WIDTH-1:0]       out_data_o,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic                              busy_o,
    output logic [PASS_W-1:0]                 pass_cnt_o
);

    localparam int unsigned PSUM_W = F_WIDTH + I_WIDTH;
    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam logic [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(sat_max(ACC_WIDTH));
    localparam logic [ACC_WIDTH-1:0] SAT_MIN = ACC_WIDTH'(sat_min(ACC_WIDTH));

    state_t              state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [PASS_W-1:0]    cnt_q, cnt_d;
    logic [PASS_W-1:0]    tgt_q, tgt_d;
    logic [PASS_W-1:0]    eff_tgt;
    logic [ACC_WIDTH:0]   sum_ext;
    logic [ACC_WIDTH-1:0] sum_sat;
    logic [ACC_WIDTH-1:0] push_data;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    always_ff @(posedge clk_i or posedge acc_rst_i) begin
        if (acc_rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
        end
    end

    assign accept  = psum_valid_i & psum_ready_o;
    assign eff_tgt = (num_passes_i == '0) ? PASS_W'(1) : num_passes_i;
    // One guard bit catches overflow; a mismatch of the top two bits selects the clamp.
    assign sum_ext = {acc_q[ACC_WIDTH-1], acc_q}
                   + {{(ACC_WIDTH + 1 - PSUM_W){psum_i[PSUM_W-1]}}, psum_i};

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        tgt_d     = tgt_q;
        push      = 1'b0;
        sum_sat   = sum_ext[ACC_WIDTH-1:0];
        if (sum_ext[ACC_WIDTH] != sum_ext[ACC_WIDTH-1])
            sum_sat = sum_ext[ACC_WIDTH] ? SAT_MIN : SAT_MAX;
`ifdef PSUM_ACC_RELU_EN
        push_data = sum_sat[ACC_WIDTH-1] ? '0 : sum_sat;
`else
        push_data = sum_sat;
`endif
        if (accept) begin
            case (state_q)
                IDLE: begin
                    tgt_d = eff_tgt;
                    if (eff_tgt == PASS_W'(1)) begin
                        push = 1'b1;
                    end else begin
                        acc_d   = sum_sat;
                        cnt_d   = PASS_W'(1);
                        state_d = ACCUM;
                    end
                end
                ACCUM: begin
                    if (cnt_q + PASS_W'(1) == tgt_q) begin
                        push    = 1'b1;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        acc_d = sum_sat;
                        cnt_d = cnt_q + PASS_W'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o       = (state_q == ACCUM);
        pass_cnt_o   = cnt_q;
        psum_ready_o = ~fifo_full;
        out_valid_o  = ~fifo_empty;
    end

    assign pop = out_valid_o & out_ready_i;

    psum_fifo #(
        .WIDTH (ACC_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (acc_rst_i),
        .push_i  (push),
        .data_i  (push_data),
        .pop_i   (pop),
        .data_o  (out_data_o),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_ff @(posedge clk_i) begin
        if (!acc_rst_i) assert (fifo_full == (fifo_count == CNT_W'(DEPTH)));
    end

endmodule

// File: tb/tb_psum_acc.sv
// Directed self-checking bench for psum_acc (ACC_WIDTH=16, DEPTH=4).
module tb_psum_acc;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [15:0] psum;
    logic               psum_valid;
    logic               psum_ready;
    logic [3:0]         num_passes;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic [3:0]         pass_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    psum_acc #(
        .F_WIDTH   (8),
        .I_WIDTH   (8),
        .ACC_WIDTH (16),
        .PASS_W    (4),
        .DEPTH     (4)
    ) dut (
        .clk_i        (clk),
        .acc_rst_i    (rst),
        .psum_i       (psum),
        .psum_valid_i (psum_valid),
        .psum_ready_o (psum_ready),
        .num_passes_i (num_passes),
        .out_data_o   (out_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .busy_o       (busy),
        .pass_cnt_o   (pass_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'sd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", out_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", pass_cnt); end
        checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", psum_ready); end
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_three_pass();
        out_ready = 1'b1; num_passes = 4'd3; psum = 16'sd10; psum_valid = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p3_busy1: got %b expected 1", busy); end
        checks++; if (pass_cnt !== 4'd1) begin errors++; $display("FAIL p3_cnt1: got %0d expected 1", pass_cnt); end
        num_passes = 4'd1; psum = -16'sd4;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL p3_busy2: got %b expected 1", busy); end
        checks++; if (pass_cnt !== 4'd2) begin errors++; $display("FAIL p3_cnt2: got %0d expected 2", pass_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p3_early_valid: got %b expected 0", out_valid); end
        psum = 16'sd7;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p3_busy3: got %b expected 0", busy); end
        checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL p3_cnt3: got %0d expected 0", pass_cnt); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL p3_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== 16'sd13) begin errors++; $display("FAIL p3_data: got %0d expected 13", out_data); end
        psum_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p3_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_pass_zero_one();
        out_ready = 1'b0; num_passes = 4'd0; psum = -16'sd5; psum_valid = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p0_busy: got %b expected 0", busy); end
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL p0_valid: got %b expected 1", out_valid); end
        checks++; if (out_data !== -16'sd5) begin errors++; $display("FAIL p0_data: got %0d expected -5", out_data); end
        num_passes = 4'd1; psum = 16'sd9;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL p1_busy: got %b expected 0", busy); end
        checks++; if (out_data !== -16'sd5) begin errors++; $display("FAIL p1_head: got %0d expected -5", out_data); end
        psum_valid = 1'b0; out_ready = 1'b1;
        tick();
        checks++; if (out_data !== 16'sd9) begin errors++; $display("FAIL p1_data: got %0d expected 9", out_data); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL p1_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_saturation();
        logic signed [15:0] exp_neg;
`ifdef PSUM_ACC_RELU_EN
        exp_neg = 16'sd0;
`else
        exp_neg = -16'sd32768;
`endif
        out_ready = 1'b1; num_passes = 4'd4; psum = 16'sd32767; psum_valid = 1'b1;
        tick(); tick(); tick();
        checks++; if (pass_cnt !== 4'd3) begin errors++; $display("FAIL sat_cnt: got %0d expected 3", pass_cnt); end
        tick();
        checks++; if (out_data !== 16'sd32767) begin errors++; $display("FAIL sat_max: got %0d expected 32767", out_data); end
        psum = -16'sd32768;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sat_popped: got %b expected 0", out_valid); end
        tick(); tick(); tick();
        checks++; if (out_data !== exp_neg) begin errors++; $display("FAIL sat_min: got %0d expected %0d", out_data, exp_neg); end
        psum_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1; num_passes = 4'd1; psum = 16'sd100; psum_valid = 1'b1;
        tick();
        checks++; if (out_data !== 16'sd100) begin errors++; $display("FAIL b2b_0: got %0d expected 100", out_data); end
        psum = 16'sd200;
        tick();
        checks++; if (out_data !== 16'sd200) begin errors++; $display("FAIL b2b_1: got %0d expected 200", out_data); end
        psum = 16'sd300;
        tick();
        checks++; if (out_data !== 16'sd300 || out_valid !== 1'b1) begin errors++; $display("FAIL b2b_2: got %0d/%b expected 300/1", out_data, out_valid); end
        psum_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0; num_passes = 4'd1; psum_valid = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            psum = 16'(k);
            checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_%0d: got %b expected 1", k, psum_ready); end
            tick();
        end
        psum = 16'sd5;
        checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", psum_ready); end
        tick(); tick();
        checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL bp_hold: got %b expected 0", psum_ready); end
        checks++; if (out_data !== 16'sd1) begin errors++; $display("FAIL bp_head: got %0d expected 1", out_data); end
        out_ready = 1'b1;
        #1;
        checks++; if (psum_ready !== 1'b0) begin errors++; $display("FAIL bp_no_lookahead: got %b expected 0", psum_ready); end
        tick();
        checks++; if (psum_ready !== 1'b1) begin errors++; $display("FAIL bp_reopen: got %b expected 1", psum_ready); end
        checks++; if (out_data !== 16'sd2) begin errors++; $display("FAIL bp_d2: got %0d expected 2", out_data); end
        tick();
        psum_valid = 1'b0;
        checks++; if (out_data !== 16'sd3) begin errors++; $display("FAIL bp_d3: got %0d expected 3", out_data); end
        tick();
        checks++; if (out_data !== 16'sd4) begin errors++; $display("FAIL bp_d4: got %0d expected 4", out_data); end
        tick();
        checks++; if (out_data !== 16'sd5 || out_valid !== 1'b1) begin errors++; $display("FAIL bp_d5: got %0d/%b expected 5/1", out_data, out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drained: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; num_passes = 4'd1; psum = 16'sd7; psum_valid = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ar_queued: got %b expected 1", out_valid); end
        num_passes = 4'd4; psum = 16'sd2;
        tick();
        psum = 16'sd3;
        tick();
        checks++; if (busy !== 1'b1 || pass_cnt !== 4'd2) begin errors++; $display("FAIL ar_mid: got %b/%0d expected 1/2", busy, pass_cnt); end
        psum_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_busy: got %b expected 0", busy); end
        checks++; if (pass_cnt !== 4'd0) begin errors++; $display("FAIL ar_cnt: got %0d expected 0", pass_cnt); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_valid: got %b expected 0", out_valid); end
        #1 rst = 1'b0;
        tick();
        out_ready = 1'b1; num_passes = 4'd2; psum = 16'sd2; psum_valid = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ar_next_busy: got %b expected 1", busy); end
        psum = 16'sd3;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== 16'sd5) begin errors++; $display("FAIL ar_next: got %0d/%b expected 5/1", out_data, out_valid); end
        psum_valid = 1'b0;
        tick();
    endtask

    task automatic test_relu();
        logic signed [15:0] exp_first;
`ifdef PSUM_ACC_RELU_EN
        exp_first = 16'sd0;
`else
        exp_first = -16'sd15;
`endif
        out_ready = 1'b1; num_passes = 4'd2; psum = -16'sd20; psum_valid = 1'b1;
        tick();
        psum = 16'sd5;
        tick();
        checks++; if (out_valid !== 1'b1 || out_data !== exp_first) begin errors++; $display("FAIL relu_neg: got %0d/%b expected %0d/1", out_data, out_valid, exp_first); end
        psum = 16'sd8;
        tick();
        psum = 16'sd1;
        tick();
        checks++; if (out_data !== 16'sd9) begin errors++; $display("FAIL relu_pos: got %0d expected 9", out_data); end
        psum_valid = 1'b0;
        tick();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL relu_drained: got %b expected 0", out_valid); end
    endtask

    initial begin
        rst = 1'b1; psum = '0; psum_valid = 1'b0; num_passes = '0; out_ready = 1'b0;
        test_reset();
        tick();
        test_three_pass();
        test_pass_zero_one();
        test_saturation();
        test_back_to_back();
        test_backpressure();
        test_async_reset();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
